// File: rtl/toggle_handshake_rx_if.sv
// Bundle of the toggle-link request side and the valid/ready consumer side.
// Latency: none, wiring only.
// Backpressure: carries rx_ready from the consumer; the req/ack toggle pair paces the sender.
interface toggle_handshake_rx_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                     req_toggle_in;
  logic [WIDTH-1:0]         data_in;
  logic                     ack_toggle_out;
  logic                     rx_valid;
  logic                     rx_ready;
  logic [WIDTH-1:0]         rx_data;
  logic [$clog2(DEPTH):0]   level;
  logic                     proto_err;
  logic                     clear_err;

  // Environment side: drives the sender and consumer inputs.
  modport master (
    output req_toggle_in, data_in, rx_ready, clear_err,
    input  ack_toggle_out, rx_valid, rx_data, level, proto_err
  );

  // Receiver block side.
  modport slave (
    input  req_toggle_in, data_in, rx_ready, clear_err,
    output ack_toggle_out, rx_valid, rx_data, level, proto_err
  );
endinterface

// File: rtl/toggle_handshake_rx.sv
// Receives a two-phase req/ack toggle link and queues words in a FWFT FIFO.
// Latency: req toggle sampled at edge 1 is written and acked at edge SYNC_STAGES+1.
// Backpressure: full FIFO withholds ack until a pop frees space (same-cycle pop counts).
module toggle_handshake_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  toggle_handshake_rx_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {IDLE, WAIT_SPACE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   seen_q, seen_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic [LW-1:0]          level_q, level_d;
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [AW-1:0]          rptr_q, rptr_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];

  logic sreq;
  logic evt;
  logic pop;
  logic push_ok;
  logic wr;
  logic err_set;

  // sreq is the synchronised request level; a mismatch with seen is an unserved transfer.
  assign sreq    = sync_q[SYNC_STAGES-1];
  assign evt     = sreq ^ seen_q;
  assign pop     = (level_q != '0) & bus.rx_ready;
  assign push_ok = (level_q < FULL) | pop;

  // Next-state: accept a transfer when there is room, otherwise park in WAIT_SPACE.
  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (evt) begin
          if (push_ok) wr = 1'b1;
          else         state_d = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        // Request reverted while still unacked: sender broke the protocol.
        if (!evt) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else if (push_ok) begin
          wr      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.req_toggle_in};
    seen_d  = wr ? sreq : seen_q;
    ack_d   = ack_q ^ wr;
    wptr_d  = wr  ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    case ({wr, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A new error in the same cycle as clear_err keeps the flag set.
    err_d = err_set | (err_q & ~bus.clear_err);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      seen_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      level_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      seen_q  <= seen_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      level_q <= level_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // FIFO storage; data_in is only captured on the write edge.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= bus.data_in;
  end

  assign bus.ack_toggle_out = ack_q;
  assign bus.rx_valid       = (level_q != '0);
  assign bus.rx_data        = mem_q[rptr_q];
  assign bus.level          = level_q;
  assign bus.proto_err      = err_q;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
`timescale 1ns/1ps
module tb_toggle_handshake_rx;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  toggle_handshake_rx_if #(.WIDTH(W), .DEPTH(D)) bus();
  toggle_handshake_rx #(.WIDTH(W), .SYNC_STAGES(SS), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of words the consumer must see, plus link-level state.
  logic [W-1:0] q[$];
  bit [SS-1:0]  hist;
  bit           m_seen, m_ack, m_err, m_wait, m_init;
  int           m_pops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model advances on each edge from the input values held across that edge.
  initial begin
    bit sreq, pop, evt, space, wr, eset;
    m_init = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        hist = '0; m_seen = 0; m_ack = 0; m_err = 0; m_wait = 0; m_init = 1;
      end else begin
        sreq  = hist[SS-1];
        pop   = (q.size() != 0) && bus.rx_ready;
        evt   = (sreq != m_seen);
        space = (q.size() < D) || pop;
        wr = 0; eset = 0;
        if (evt && space) begin wr = 1; m_wait = 0; end
        else if (evt) m_wait = 1;
        else if (m_wait) begin eset = 1; m_wait = 0; end
        if (pop) begin void'(q.pop_front()); m_pops++; end
        if (wr) begin q.push_back(bus.data_in); m_seen = sreq; m_ack = ~m_ack; end
        if (eset) m_err = 1;
        else if (bus.clear_err) m_err = 0;
        hist = {hist[SS-2:0], bus.req_toggle_in};
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("level", 32'(bus.level), 32'(q.size()));
        chk("rx_valid", 32'(bus.rx_valid), 32'(q.size() != 0));
        chk("ack", 32'(bus.ack_toggle_out), 32'(m_ack));
        chk("proto_err", 32'(bus.proto_err), 32'(m_err));
        if (q.size() != 0) chk("rx_data", 32'(bus.rx_data), 32'(q[0]));
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit wait_ack);
    logic a0;
    int   n;
    a0 = bus.ack_toggle_out;
    n  = 0;
    bus.data_in       = d;
    bus.req_toggle_in = ~bus.req_toggle_in;
    if (wait_ack) begin
      while (bus.ack_toggle_out == a0 && n < 60) begin
        tick();
        n++;
      end
      if (n >= 60) begin
        checks++;
        failures++;
        $display("FAIL ack_timeout waited=%0d cycles data=%0h", n, d);
      end
    end
  endtask

  task automatic pop_expect(input logic [W-1:0] e, input string nm);
    chk({nm, "_valid"}, 32'(bus.rx_valid), 32'd1);
    chk(nm, 32'(bus.rx_data), 32'(e));
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
  endtask

  initial begin
    int  pops0;
    bit  done;
    bus.req_toggle_in = 1'b0;
    bus.data_in       = '0;
    bus.rx_ready      = 1'b0;
    bus.clear_err     = 1'b0;
    repeat (3) tick();
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_ack", 32'(bus.ack_toggle_out), 32'd0);
    chk("rst_err", 32'(bus.proto_err), 32'd0);
    rst = 1'b0;

    // First transfer: write lands on edge 3.
    bus.data_in = 8'hA5;
    bus.req_toggle_in = 1'b1;
    tick(); tick();
    chk("t1_level_edge2", 32'(bus.level), 32'd0);
    tick();
    chk("t1_level", 32'(bus.level), 32'd1);
    chk("t1_ack", 32'(bus.ack_toggle_out), 32'd1);
    chk("t1_data", 32'(bus.rx_data), 32'hA5);
    pop_expect(8'hA5, "t1_pop");

    // Fill, stall a fifth word, then a single pop admits it on the same edge.
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h44, 1);
    chk("t2_full_level", 32'(bus.level), 32'd4);
    chk("t2_full_ack", 32'(bus.ack_toggle_out), 32'd1);
    send(8'h55, 0);
    repeat (8) tick();
    chk("t2_stall_ack", 32'(bus.ack_toggle_out), 32'd1);
    chk("t2_stall_level", 32'(bus.level), 32'd4);
    pop_expect(8'h11, "t2_pop11");
    chk("t2_after_level", 32'(bus.level), 32'd4);
    chk("t2_after_ack", 32'(bus.ack_toggle_out), 32'd0);
    pop_expect(8'h22, "t2_d22"); pop_expect(8'h33, "t2_d33");
    pop_expect(8'h44, "t2_d44"); pop_expect(8'h55, "t2_d55");
    chk("t2_empty", 32'(bus.rx_valid), 32'd0);

    // Protocol error: request reverted while waiting for space.
    send(8'h61, 1); send(8'h62, 1); send(8'h63, 1); send(8'h64, 1);
    send(8'h66, 0);
    repeat (6) tick();
    chk("t4_wait_err", 32'(bus.proto_err), 32'd0);
    bus.req_toggle_in = ~bus.req_toggle_in;
    repeat (4) tick();
    chk("t4_err", 32'(bus.proto_err), 32'd1);
    chk("t4_level", 32'(bus.level), 32'd4);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    chk("t4_cleared", 32'(bus.proto_err), 32'd0);
    pop_expect(8'h61, "t4_d61"); pop_expect(8'h62, "t4_d62");
    pop_expect(8'h63, "t4_d63"); pop_expect(8'h64, "t4_d64");

    // Reset mid-stream with data queued and ack high.
    send(8'h71, 1); send(8'h72, 1); send(8'h73, 1);
    chk("t5_pre_level", 32'(bus.level), 32'd3);
    chk("t5_pre_ack", 32'(bus.ack_toggle_out), 32'd1);
    rst = 1'b1;
    bus.req_toggle_in = 1'b0;
    tick();
    chk("t5_level", 32'(bus.level), 32'd0);
    chk("t5_valid", 32'(bus.rx_valid), 32'd0);
    chk("t5_ack", 32'(bus.ack_toggle_out), 32'd0);
    chk("t5_err", 32'(bus.proto_err), 32'd0);
    rst = 1'b0;
    tick();

    // Random traffic: random sender gaps with garbage data, random consumer stalls.
    pops0 = m_pops;
    done  = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int dly;
          dly = $urandom_range(0, 3);
          for (int k = 0; k < dly; k++) begin
            bus.data_in = W'($urandom);
            tick();
          end
          send(W'($urandom), 1);
        end
        done = 1;
      end
      begin
        while (!done) begin
          bus.rx_ready = ($urandom_range(0, 3) == 0);
          tick();
        end
      end
    join
    bus.rx_ready = 1'b1;
    repeat (20) tick();
    chk("t6_pops", 32'(m_pops - pops0), 32'd1000);
    chk("t6_drained", 32'(bus.level), 32'd0);
    chk("t6_no_err", 32'(bus.proto_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
